// File: rtl/branch_fetch.sv
// -----------------------------------------------------------------------------
// branch_fetch
//   PC generation and instruction fetch stage feeding the branch pipeline.
//   Issues in-order fetch requests, buffers returned instructions in a small
//   FIFO whose head is presented to decode, and handles redirects from branch
//   execute by reloading the PC, flushing the FIFO and discarding responses
//   that belong to the wrong path.
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   stall            global pipeline stall, holds the decode-facing outputs
//   branch_taken     redirect request from branch execute
//   new_pc           redirect target (word aligned internally)
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    fetch address
//   imem_resp_valid  in-order response valid, at most one per cycle
//   imem_resp_data   fetched instruction
//   inst             instruction to decode, NOP_INST when inst_valid=0
//   inst_pc          PC of inst, 0 when inst_valid=0
//   inst_valid       FIFO head is valid
//   branch_squash    kills the instruction currently in decode
// -----------------------------------------------------------------------------
module branch_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_INCR     = 4,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] new_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        branch_squash
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] QD_W = (CW + 1)'(QUEUE_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0] trd_q, trd_d, twr_q, twr_d;

    logic [31:0] data_q [QUEUE_DEPTH];
    logic [31:0] pc_q   [QUEUE_DEPTH];
    logic [31:0] tag_q  [QUEUE_DEPTH];

    logic        head_valid;
    logic        pop;
    logic        push;
    logic        hs;
    logic [CW:0] used;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid && !stall && !branch_taken;
    assign push       = imem_resp_valid && !branch_taken && (drop_q == '0);

    // The head leaving this cycle is counted as already free, so a 1-cycle
    // memory can sustain one fetch per cycle with only two slots. Under stall
    // no pop happens and the budget is simply occupancy + inflight.
    assign used = (CW + 1)'(count_q) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);

    assign imem_req_valid = rst && !branch_taken && (used < QD_W);
    assign imem_req_addr  = fetch_pc_q;
    assign hs             = imem_req_valid && imem_req_ready;

    assign inst_valid    = head_valid;
    assign inst          = head_valid ? data_q[rd_q] : NOP_INST;
    assign inst_pc       = head_valid ? pc_q[rd_q]   : '0;
    assign branch_squash = branch_taken;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(hs) - CW'(imem_resp_valid);
        drop_d     = drop_q;
        count_d    = count_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        // Tags are consumed by every response, including discarded ones, so
        // the tag FIFO stays aligned with the memory's response stream.
        twr_d      = twr_q + PW'(hs);
        trd_d      = trd_q + PW'(imem_resp_valid);

        if (branch_taken) begin
            fetch_pc_d = new_pc & ~32'h3;
            // A response arriving now is already gone; only the rest are stale.
            drop_d     = inflight_q - CW'(imem_resp_valid);
            count_d    = '0;
            rd_d       = wr_q;
        end else begin
            if (hs) begin
                fetch_pc_d = fetch_pc_q + 32'(PC_INCR);
            end
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            rd_d    = rd_q + PW'(pop);
            wr_d    = wr_q + PW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            trd_q      <= '0;
            twr_q      <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            trd_q      <= trd_d;
            twr_q      <= twr_d;
            if (hs) begin
                tag_q[twr_q] <= fetch_pc_q;
            end
            if (push) begin
                data_q[wr_q] <= imem_resp_data;
                pc_q[wr_q]   <= tag_q[trd_q];
            end
        end
    end

    a_no_full_push: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == CW'(QUEUE_DEPTH))));

    a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst)
        (drop_q <= inflight_q) && (inflight_q <= CW'(QUEUE_DEPTH)));

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_branch_fetch.sv
// -----------------------------------------------------------------------------
// tb_branch_fetch
//   Self-checking bench for branch_fetch: a directed vector table for the
//   start-up/stall/redirect timeline, hand-written corner sequences, and a
//   randomized phase, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_fetch;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int unsigned PC_INCR     = 4;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam logic [31:0] NOP_INST    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] new_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        branch_squash;

    branch_fetch #(
        .RESET_PC   (RESET_PC),
        .PC_INCR    (PC_INCR),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .NOP_INST   (NOP_INST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .new_pc         (new_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .branch_squash  (branch_squash)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight fetches and the decode queue as plain queues.
    typedef struct { logic [31:0] pc; logic [31:0] data; bit live; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } fe_t;
    typedef struct { int unsigned due; logic [31:0] data; } mr_t;

    fl_t         m_infl[$];
    fe_t         m_fifo[$];
    logic [31:0] m_pc;

    // Memory environment: in-order, one response per cycle.
    mr_t         mem_q[$];
    int unsigned cyc;
    int unsigned lat_lo, lat_hi, rdy_pct;
    logic [31:0] key;

    // Samples from the most recent cycle.
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out at cycle %0d got 0 expected 1", name, cyc);
    endtask

    task automatic cycle(input bit st, input bit bt, input logic [31:0] npc);
        bit          resp, pop_m, rv_m;
        int          used;
        fl_t         r;
        logic [31:0] e_inst, e_pc;
        bit          e_iv;
        stall          = st;
        branch_taken   = bt;
        new_pc         = npc;
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        resp           = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_q[0].data : $urandom;
        #1;
        e_iv   = (m_fifo.size() > 0);
        e_inst = e_iv ? m_fifo[0].data : NOP_INST;
        e_pc   = e_iv ? m_fifo[0].pc : 32'h0;
        pop_m  = e_iv && !st && !bt;
        used   = m_fifo.size() + m_infl.size() - int'(pop_m);
        rv_m   = !bt && (used < int'(QUEUE_DEPTH));
        s_rv = imem_req_valid; s_iv = inst_valid; s_addr = imem_req_addr; s_pc = inst_pc;
        chk("squash", {31'b0, branch_squash}, {31'b0, bt});
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, rv_m});
        chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
        chk("inst", inst, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        // model update
        if (resp) begin
            if (m_infl.size() == 0) begin
                n_total++;
                $display("FAIL resp_has_req at cycle %0d: got response expected none outstanding", cyc);
            end else begin
                r = m_infl.pop_front();
                if (r.live && !bt) m_fifo.push_back('{pc: r.pc, data: r.data});
            end
        end
        if (bt) begin
            foreach (m_infl[i]) m_infl[i].live = 0;
            m_fifo.delete();
            m_pc = {npc[31:2], 2'b00};
        end else begin
            if (pop_m) void'(m_fifo.pop_front());
            if (rv_m && imem_req_ready) begin
                m_infl.push_back('{pc: m_pc, data: key ^ m_pc, live: 1'b1});
                m_pc = m_pc + PC_INCR;
            end
        end
        // memory update, driven by what the DUT actually issued
        if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{due: cyc + $urandom_range(lat_lo, lat_hi), data: key ^ imem_req_addr});
        if (resp) void'(mem_q.pop_front());
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; new_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst", inst, NOP_INST);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        mem_q.delete(); m_fifo.delete(); m_infl.delete();
        m_pc = RESET_PC;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        cyc += 2;
    endtask

    typedef struct {
        bit st; bit bt; logic [31:0] npc;
        bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;
    } vec_t;

    vec_t tbl[15];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        logic [31:0] hp;

        // 1-cycle memory, data = address; startup, stall, release, redirect.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h10};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h14};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h18};
        tbl[11] = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h24,  1'b1, 32'h1C};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h00};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h00};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};

        cyc = 0; key = 32'h0; lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        rst = 1'b0;
        #1;
        do_reset();

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].bt, tbl[i].npc);
            chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, tbl[i].rv});
            chk("tbl_req_addr", s_addr, tbl[i].addr);
            chk("tbl_inst_valid", {31'b0, s_iv}, {31'b0, tbl[i].iv});
            chk("tbl_inst_pc", s_pc, tbl[i].pc);
        end

        key = 32'h5A5A_0000;

        // Five-cycle stall while streaming: head held.
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_fifo.size() > 0) begin found = 1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout_fail("stall_setup");
        else begin
            hp = m_fifo[0].pc;
            for (int i = 0; i < 5; i++) begin
                cycle(1'b1, 1'b0, 32'h0);
                chk("stall_hold_pc", s_pc, hp);
            end
            for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
        end

        // Redirect to 0x103 with two fetches in flight, latency 3.
        lat_lo = 3; lat_hi = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_infl.size() == 2) begin found = 1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout_fail("redir_setup");
        cycle(1'b0, 1'b1, 32'h103);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_rv) begin found = 1; break; end
        end
        if (!found) timeout_fail("redir_req");
        else chk("redir_addr", s_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_iv) begin found = 1; break; end
        end
        if (!found) timeout_fail("redir_inst");
        else chk("redir_first_pc", s_pc, 32'h100);

        // Redirect under stall still flushes.
        lat_lo = 1; lat_hi = 1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_fifo.size() > 0) begin found = 1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout_fail("stall_redir_setup");
        cycle(1'b1, 1'b1, 32'h400);
        cycle(1'b1, 1'b0, 32'h0);
        chk("stall_redir_flush", {31'b0, s_iv}, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

        // Back-to-back redirects with a response in each cycle.
        lat_lo = 2; lat_hi = 2;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_q.size() >= 2 && mem_q[0].due == cyc && mem_q[1].due == cyc + 1) begin
                found = 1; break;
            end
            cycle(1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout_fail("b2b_setup");
        cycle(1'b0, 1'b1, 32'h200);
        cycle(1'b0, 1'b1, 32'h300);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_iv) begin found = 1; break; end
        end
        if (!found) timeout_fail("b2b_inst");
        else chk("b2b_first_pc", s_pc, 32'h300);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

        // Reset mid-stream with two fetches in flight.
        lat_lo = 3; lat_hi = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_infl.size() == 2) begin found = 1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        if (!found) timeout_fail("rst_setup");
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        chk("rst_restart_valid", {31'b0, s_rv}, 32'h1);
        chk("rst_restart_addr", s_addr, RESET_PC);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (s_iv) begin found = 1; break; end
        end
        if (!found) timeout_fail("rst_restart_inst");
        else chk("rst_restart_pc", s_pc, RESET_PC);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4; rdy_pct = 75;
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_fetch.md
Name: branch_fetch

Overview:
PC generation and instruction-fetch stage that sits directly upstream of the branch pipeline.
- Issues in-order instruction-memory requests through a valid/ready handshake.
- Buffers returned instructions in a small FIFO and presents the head as inst/inst_pc to decode.
- On branch_taken from the branch execute stage, redirects to new_pc, flushes buffered and in-flight wrong-path instructions, and drives branch_squash.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- PC_INCR, 4, byte increment between sequential fetches.
- QUEUE_DEPTH, 2, fetch FIFO entries; also the cap on queued plus in-flight fetches (power of 2, ≥2).
- NOP_INST, 32'h0000_0000, encoding driven on inst when no valid instruction is presented.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  global pipeline stall; holds the decode-facing outputs.
- branch_taken  input  1  redirect request from branch execute.
- new_pc  input  32  redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  fetch address.
- imem_resp_valid  input  1  response valid; responses return in order, latency ≥1 cycle, at most one per cycle.
- imem_resp_data  input  32  fetched instruction.
- inst  output  32  instruction to decode; NOP_INST when inst_valid=0.
- inst_pc  output  32  PC of inst; 0 when inst_valid=0.
- inst_valid  output  1  FIFO head is valid.
- branch_squash  output  1  kills the instruction currently in decode.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst=NOP_INST, inst_pc=0, inst_valid=0.
  - Reset mid-operation discards all state, including outstanding responses. Memory must be reset together with this block.
- Issue:
  - imem_req_valid = !branch_taken && (occupancy + inflight < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake (valid&&ready): fetch_pc += PC_INCR (wraps mod 2^32) and inflight++.
  - imem_req_valid is not gated by stall; the budget alone limits fetches.
- Response:
  - Decrements inflight.
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise {data, pc} is pushed into the FIFO; the PC tag comes from a parallel PC-tag FIFO written at issue.
  - The budget guarantees no push into a full FIFO. A push into a full FIFO is an assertion failure.
- Pop:
  - Occurs when inst_valid && !stall && !branch_taken.
  - Push and pop in the same cycle keep occupancy unchanged.
  - With an empty FIFO, a response is visible on inst the cycle after it arrives (no bypass).
- Stall: inst, inst_pc and inst_valid are held; no pop. Fetch continues until the budget is exhausted.
- Redirect (branch_taken=1 at cycle T, wins over stall):
  - branch_squash = branch_taken, combinational, same cycle T.
  - imem_req_valid is forced 0 in T.
  - At the T edge:
    - fetch_pc = {new_pc[31:2], 2'b00};
    - FIFO cleared;
    - drop_cnt = inflight − (imem_resp_valid ? 1 : 0);
    - a response arriving in T is discarded.
  - T+1: imem_req_valid=1 at the new PC (budget permitting); inst_valid=0.
  - Back-to-back redirects: each redirect reloads fetch_pc and recomputes drop_cnt from the current inflight.
- Counters:
  - inflight and drop_cnt are clog2(QUEUE_DEPTH)+1 bits wide.
  - Invariant: drop_cnt ≤ inflight ≤ QUEUE_DEPTH.
- Steady-state throughput: one instruction per cycle with a 1-cycle memory and QUEUE_DEPTH=2.

Test Plan:
1. Reset release, ready=1, 1-cycle memory returning addr as data → requests at 0x0, 0x4, 0x8…; inst_valid rises 2 cycles after the first request; inst/inst_pc show 0x0/0x0, then 0x4/0x4…, one per cycle.
2. Hold stall=1 for 5 cycles during streaming → inst/inst_pc frozen; at most 2 requests outstanding+queued; after release, no instruction is lost or duplicated (PC sequence contiguous).
3. branch_taken=1, new_pc=0x103 with 2 requests in flight and latency 3 → branch_squash=1 the same cycle; next request addr 0x100; both stale responses dropped; first inst_pc after the redirect is 0x100.
4. branch_taken asserted while stall=1 → the redirect is still taken; FIFO flushed; inst_valid=0 the next cycle.
5. Redirects on two consecutive cycles (0x200, then 0x300) with a response arriving in each → only the 0x300 path reaches inst; drop_cnt returns to 0.
6. Assert rst=0 mid-stream with 2 in flight → all outputs take their reset values immediately; after release, the fetch restarts at RESET_PC.
